// File: rtl/expmul_scheduler.sv
// -----------------------------------------------------------------------------
// expmul_scheduler
//
// Issues the exp-multiply operations for one online-softmax row. For each
// incoming Q4.4 score it updates the running row maximum and issues up to two
// ops to the shared exp-multiply stage:
//   rescale (em_o_star_mode=1): exp(m_old - m_new) applied to the O* accumulator
//   scale   (em_o_star_mode=0): exp(s - m_new) applied to the V row
// It also counts the KV tokens of each query and flags that query's last one.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   seq_len         tokens per query, sampled on the first token of a query
//   s_vld/s_rdy/s_in          score input handshake, signed Q4.4 score
//   em_vld/em_rdy             op handshake to the exp-multiply stage
//   em_a, em_b                minuend / subtrahend (em_a - em_b <= 0)
//   em_o_star_mode            1 = rescale O*, 0 = scale V
//   em_last                   scale op of the last token of the query
//   kv_idx                    index of the token being processed
//   m_run                     current running maximum
//   query_done                one-cycle pulse after the last scale op
// -----------------------------------------------------------------------------
module expmul_scheduler #(
   parameter int MAX_SEQ_LENGTH  = 64,
   parameter int SCORE_W         = 8,
   parameter int SKIP_EQ_RESCALE = 1,
   localparam int LEN_W = $clog2(MAX_SEQ_LENGTH) + 1,
   localparam int IDX_W = $clog2(MAX_SEQ_LENGTH)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [LEN_W-1:0]   seq_len,
   input  logic               s_vld,
   output logic               s_rdy,
   input  logic [SCORE_W-1:0] s_in,
   output logic               em_vld,
   input  logic               em_rdy,
   output logic [SCORE_W-1:0] em_a,
   output logic [SCORE_W-1:0] em_b,
   output logic               em_o_star_mode,
   output logic               em_last,
   output logic [IDX_W-1:0]   kv_idx,
   output logic [SCORE_W-1:0] m_run,
   output logic               query_done
);

   typedef enum logic [1:0] {IDLE, RESC, SCALE} state_t;

   // Most-negative signed score: the identity element for max().
   localparam logic [SCORE_W-1:0] M_MIN = {1'b1, {(SCORE_W-1){1'b0}}};

   state_t             state_q,      state_d;
   logic [IDX_W-1:0]   kv_idx_q,     kv_idx_d;
   logic [SCORE_W-1:0] m_run_q,      m_run_d;
   logic [SCORE_W-1:0] m_new_q,      m_new_d;
   logic [SCORE_W-1:0] s_q,          s_d;
   logic [LEN_W-1:0]   len_q,        len_d;
   logic               first_tok_q,  first_tok_d;
   logic               query_done_q, query_done_d;

   logic [SCORE_W-1:0] m_new_c;
   logic               is_last;

   assign m_new_c = ($signed(s_in) > $signed(m_run_q)) ? s_in : m_run_q;
   assign is_last = ({1'b0, kv_idx_q} == LEN_W'(len_q - LEN_W'(1)));

   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // through the case statement leaves one unassigned (which would infer a latch).
      state_d        = state_q;
      kv_idx_d       = kv_idx_q;
      m_run_d        = m_run_q;
      m_new_d        = m_new_q;
      s_d            = s_q;
      len_d          = len_q;
      first_tok_d    = first_tok_q;
      query_done_d   = 1'b0;
      s_rdy          = 1'b0;
      em_vld         = 1'b0;
      em_a           = '0;
      em_b           = '0;
      em_o_star_mode = 1'b0;
      em_last        = 1'b0;

      case (state_q)
         IDLE: begin
            s_rdy = 1'b1;
            if (s_vld) begin
               s_d     = s_in;
               m_new_d = m_new_c;
               if (first_tok_q) begin
                  // First token defines the maximum; no O* exists yet to rescale.
                  len_d       = seq_len;
                  m_run_d     = s_in;
                  first_tok_d = 1'b0;
                  state_d     = SCALE;
               end else if ((SKIP_EQ_RESCALE != 0) && (m_new_c == m_run_q)) begin
                  state_d = SCALE;
               end else begin
                  state_d = RESC;
               end
            end
         end

         RESC: begin
            em_vld         = 1'b1;
            em_a           = m_run_q;
            em_b           = m_new_q;
            em_o_star_mode = 1'b1;
            if (em_rdy) begin
               m_run_d = m_new_q;
               state_d = SCALE;
            end
         end

         SCALE: begin
            em_vld  = 1'b1;
            em_a    = s_q;
            em_b    = m_run_q;
            em_last = is_last;
            if (em_rdy) begin
               state_d = IDLE;
               if (is_last) begin
                  kv_idx_d     = '0;
                  first_tok_d  = 1'b1;
                  m_run_d      = M_MIN;
                  query_done_d = 1'b1;
               end else begin
                  kv_idx_d = kv_idx_q + IDX_W'(1);
               end
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the values computed before the edge, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         kv_idx_q     <= '0;
         m_run_q      <= M_MIN;
         m_new_q      <= '0;
         s_q          <= '0;
         len_q        <= '0;
         first_tok_q  <= 1'b1;
         query_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         kv_idx_q     <= kv_idx_d;
         m_run_q      <= m_run_d;
         m_new_q      <= m_new_d;
         s_q          <= s_d;
         len_q        <= len_d;
         first_tok_q  <= first_tok_d;
         query_done_q <= query_done_d;
      end
   end

   assign kv_idx     = kv_idx_q;
   assign m_run      = m_run_q;
   assign query_done = query_done_q;

endmodule

// File: tb/tb_expmul_scheduler.sv
// -----------------------------------------------------------------------------
// tb_expmul_scheduler
//
// Directed bench for expmul_scheduler. A table of per-score records (score,
// expected rescale/scale ops, last flag, token index) drives the main flow;
// hand-written sequences cover backpressure, reset mid-op and the
// SKIP_EQ_RESCALE=0 variant (a second instance).
// -----------------------------------------------------------------------------
module tb_expmul_scheduler;

   logic       clk = 1'b0;
   logic       rst;
   logic [6:0] seq_len;
   logic       s_vld;
   logic [7:0] s_in;
   logic       em_rdy;
   logic       use_ns;

   // Skipping instance
   logic       a_s_rdy, a_em_vld, a_mode, a_last, a_qd;
   logic [7:0] a_em_a, a_em_b, a_m_run;
   logic [5:0] a_kv;
   // Non-skipping instance
   logic       b_s_rdy, b_em_vld, b_mode, b_last, b_qd;
   logic [7:0] b_em_a, b_em_b, b_m_run;
   logic [5:0] b_kv;

   // Observed outputs of whichever instance is under test
   logic       o_s_rdy, o_em_vld, o_mode, o_last, o_qd;
   logic [7:0] o_em_a, o_em_b, o_m_run;
   logic [5:0] o_kv;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   expmul_scheduler #(.MAX_SEQ_LENGTH(64), .SCORE_W(8), .SKIP_EQ_RESCALE(1)) dut (
      .clk(clk), .rst(rst), .seq_len(seq_len), .s_vld(s_vld & ~use_ns), .s_rdy(a_s_rdy),
      .s_in(s_in), .em_vld(a_em_vld), .em_rdy(em_rdy), .em_a(a_em_a), .em_b(a_em_b),
      .em_o_star_mode(a_mode), .em_last(a_last), .kv_idx(a_kv), .m_run(a_m_run),
      .query_done(a_qd)
   );

   expmul_scheduler #(.MAX_SEQ_LENGTH(64), .SCORE_W(8), .SKIP_EQ_RESCALE(0)) dut_ns (
      .clk(clk), .rst(rst), .seq_len(seq_len), .s_vld(s_vld & use_ns), .s_rdy(b_s_rdy),
      .s_in(s_in), .em_vld(b_em_vld), .em_rdy(em_rdy), .em_a(b_em_a), .em_b(b_em_b),
      .em_o_star_mode(b_mode), .em_last(b_last), .kv_idx(b_kv), .m_run(b_m_run),
      .query_done(b_qd)
   );

   always_comb begin
      o_s_rdy  = use_ns ? b_s_rdy  : a_s_rdy;
      o_em_vld = use_ns ? b_em_vld : a_em_vld;
      o_mode   = use_ns ? b_mode   : a_mode;
      o_last   = use_ns ? b_last   : a_last;
      o_qd     = use_ns ? b_qd     : a_qd;
      o_em_a   = use_ns ? b_em_a   : a_em_a;
      o_em_b   = use_ns ? b_em_b   : a_em_b;
      o_m_run  = use_ns ? b_m_run  : a_m_run;
      o_kv     = use_ns ? b_kv     : a_kv;
   end

   typedef struct {
      logic [6:0] len;
      logic [7:0] score;
      bit         resc;
      logic [7:0] ra, rb;
      logic [7:0] sa, sb;
      bit         last;
      logic [5:0] idx;
   } vec_t;

   vec_t vecs[12];

   function automatic vec_t mk(logic [6:0] len, logic [7:0] score, bit resc,
                               logic [7:0] ra, logic [7:0] rb, logic [7:0] sa,
                               logic [7:0] sb, bit last, logic [5:0] idx);
      vec_t v;
      v.len = len; v.score = score; v.resc = resc; v.ra = ra; v.rb = rb;
      v.sa = sa; v.sb = sb; v.last = last; v.idx = idx;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Outputs depend only on registered state, so sampling 1 time unit after
   // the edge sees settled values; inputs are changed at the same point.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one score, wait for acceptance, check first-op latency.
   task automatic send(input logic [6:0] len, input logic [7:0] score);
      int n = 0;
      while (!o_s_rdy && n < 20) begin
         tick();
         n++;
      end
      check("s_rdy_timeout", {31'd0, o_s_rdy}, 32'd1);
      seq_len = len;
      s_in    = score;
      s_vld   = 1'b1;
      tick();
      s_vld   = 1'b0;
      check("accept_latency_em_vld", {31'd0, o_em_vld}, 32'd1);
      check("s_rdy_busy", {31'd0, o_s_rdy}, 32'd0);
   endtask

   // Check the op currently offered; consume it if em_rdy is high.
   task automatic expect_op(input string name, input bit mode, input logic [7:0] a,
                            input logic [7:0] b, input bit last);
      int n = 0;
      while (!o_em_vld && n < 20) begin
         tick();
         n++;
      end
      check({name, "_vld"},  {31'd0, o_em_vld}, 32'd1);
      check({name, "_mode"}, {31'd0, o_mode},   {31'd0, mode});
      check({name, "_a"},    {24'd0, o_em_a},   {24'd0, a});
      check({name, "_b"},    {24'd0, o_em_b},   {24'd0, b});
      check({name, "_last"}, {31'd0, o_last},   {31'd0, last});
      if (em_rdy) tick();
   endtask

   initial begin
      // Query A: seq_len 3, rising then falling scores
      vecs[0]  = mk(7'd3, 8'h10, 0, 8'h00, 8'h00, 8'h10, 8'h10, 0, 6'd0);
      vecs[1]  = mk(7'd3, 8'h20, 1, 8'h10, 8'h20, 8'h20, 8'h20, 0, 6'd1);
      vecs[2]  = mk(7'd3, 8'h08, 0, 8'h00, 8'h00, 8'h08, 8'h20, 1, 6'd2);
      // Query B: negative scores; seq_len 7 on the second token must be ignored
      vecs[3]  = mk(7'd2, 8'hF0, 0, 8'h00, 8'h00, 8'hF0, 8'hF0, 0, 6'd0);
      vecs[4]  = mk(7'd7, 8'hE0, 0, 8'h00, 8'h00, 8'hE0, 8'hF0, 1, 6'd1);
      // Back-to-back: seq_len 2 then seq_len 1
      vecs[5]  = mk(7'd2, 8'h30, 0, 8'h00, 8'h00, 8'h30, 8'h30, 0, 6'd0);
      vecs[6]  = mk(7'd2, 8'h40, 1, 8'h30, 8'h40, 8'h40, 8'h40, 1, 6'd1);
      vecs[7]  = mk(7'd1, 8'h05, 0, 8'h00, 8'h00, 8'h05, 8'h05, 1, 6'd0);
      // seq_len 1 again: every token first and last
      vecs[8]  = mk(7'd1, 8'hC0, 0, 8'h00, 8'h00, 8'hC0, 8'hC0, 1, 6'd0);
      // 0x80 on a non-first token: max unchanged, no rescale
      vecs[9]  = mk(7'd2, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 6'd0);
      vecs[10] = mk(7'd2, 8'h80, 0, 8'h00, 8'h00, 8'h80, 8'h00, 1, 6'd1);
      // Single-token query with the most negative score
      vecs[11] = mk(7'd1, 8'h80, 0, 8'h00, 8'h00, 8'h80, 8'h80, 1, 6'd0);

      rst = 1'b1; seq_len = '0; s_vld = 1'b0; s_in = '0; em_rdy = 1'b1; use_ns = 1'b0;
      tick(); tick();
      rst = 1'b0;

      check("rst_s_rdy",  {31'd0, o_s_rdy},  32'd1);
      check("rst_em_vld", {31'd0, o_em_vld}, 32'd0);
      check("rst_em_a",   {24'd0, o_em_a},   32'd0);
      check("rst_em_b",   {24'd0, o_em_b},   32'd0);
      check("rst_mode",   {31'd0, o_mode},   32'd0);
      check("rst_last",   {31'd0, o_last},   32'd0);
      check("rst_kv_idx", {26'd0, o_kv},     32'd0);
      check("rst_m_run",  {24'd0, o_m_run},  32'h80);
      check("rst_qd",     {31'd0, o_qd},     32'd0);

      for (int i = 0; i < 12; i++) begin
         send(vecs[i].len, vecs[i].score);
         check($sformatf("v%0d_kv_idx", i), {26'd0, o_kv}, {26'd0, vecs[i].idx});
         if (vecs[i].resc)
            expect_op($sformatf("v%0d_R", i), 1'b1, vecs[i].ra, vecs[i].rb, 1'b0);
         expect_op($sformatf("v%0d_S", i), 1'b0, vecs[i].sa, vecs[i].sb, vecs[i].last);
         check($sformatf("v%0d_query_done", i), {31'd0, o_qd}, {31'd0, vecs[i].last});
         if (vecs[i].last)
            check($sformatf("v%0d_m_run_reset", i), {24'd0, o_m_run}, 32'h80);
         else
            check($sformatf("v%0d_em_vld_idle", i), {31'd0, o_em_vld}, 32'd0);
      end

      // query_done is a single-cycle pulse
      tick();
      check("qd_pulse_width", {31'd0, o_qd}, 32'd0);

      // Backpressure held for 4 cycles in RESC
      send(7'd2, 8'h10);
      expect_op("bp_S0", 1'b0, 8'h10, 8'h10, 1'b0);
      em_rdy = 1'b0;
      send(7'd2, 8'h20);
      for (int c = 0; c < 4; c++) begin
         check($sformatf("bp%0d_vld", c),   {31'd0, o_em_vld}, 32'd1);
         check($sformatf("bp%0d_mode", c),  {31'd0, o_mode},   32'd1);
         check($sformatf("bp%0d_a", c),     {24'd0, o_em_a},   32'h10);
         check($sformatf("bp%0d_b", c),     {24'd0, o_em_b},   32'h20);
         check($sformatf("bp%0d_s_rdy", c), {31'd0, o_s_rdy},  32'd0);
         tick();
      end
      em_rdy = 1'b1;
      expect_op("bp_R", 1'b1, 8'h10, 8'h20, 1'b0);
      expect_op("bp_S1", 1'b0, 8'h20, 8'h20, 1'b1);
      check("bp_query_done", {31'd0, o_qd}, 32'd1);

      // Reset during SCALE with em_rdy low, mid-query (kv_idx 1)
      send(7'd3, 8'h50);
      expect_op("rs_S0", 1'b0, 8'h50, 8'h50, 1'b0);
      em_rdy = 1'b0;
      send(7'd3, 8'h40);
      check("rs_pre_kv_idx", {26'd0, o_kv}, 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rs_em_vld", {31'd0, o_em_vld}, 32'd0);
      check("rs_s_rdy",  {31'd0, o_s_rdy},  32'd1);
      check("rs_kv_idx", {26'd0, o_kv},     32'd0);
      check("rs_m_run",  {24'd0, o_m_run},  32'h80);
      em_rdy = 1'b1;
      send(7'd1, 8'h20);
      expect_op("rs_first", 1'b0, 8'h20, 8'h20, 1'b1);
      check("rs_query_done", {31'd0, o_qd}, 32'd1);

      // Non-skipping instance: equal scores still get a rescale with a == b
      use_ns = 1'b1;
      tick();
      send(7'd2, 8'h10);
      expect_op("ns_S0", 1'b0, 8'h10, 8'h10, 1'b0);
      send(7'd2, 8'h10);
      expect_op("ns_R", 1'b1, 8'h10, 8'h10, 1'b0);
      expect_op("ns_S1", 1'b0, 8'h10, 8'h10, 1'b1);
      check("ns_query_done", {31'd0, o_qd}, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
